// File: rtl/mod_commut_pkg.sv
// mod_commut_pkg: shared types and defaults for the commutator link (tx and rx sides)
// Contents: state enum, default beat/word widths, beat-counter width helper.
package mod_commut_pkg;
    typedef enum logic {IDLE, COLLECT} state_e;
    localparam int unsigned DEF_IN_WIDTH  = 8;
    localparam int unsigned DEF_OUT_WIDTH = 32;
    function automatic int unsigned cnt_w(input int unsigned beats);
        return $clog2(beats + 1);
    endfunction
endpackage

// File: rtl/mod_commut_gap_timer.sv
// mod_commut_gap_timer: loadable down-counter flagging an idle gap of CYC cycles
// Ports: clk, rst_n (async active-low), load_i (reload to CYC), dec_i (count one idle cycle),
//        expire_o (combinational: this idle cycle is the CYC-th in a row).
module mod_commut_gap_timer #(
    parameter int unsigned CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);
    localparam int unsigned W = $clog2(CYC + 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= W'(CYC);
        else if (load_i) cnt_q <= W'(CYC);
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign expire_o = dec_i && cnt_q == W'(1);
endmodule

// File: rtl/mod_rx_commut.sv
// mod_rx_commut: receive-side commutator, deserializes NUMB_OF_BEATS narrow beats (LS beat first) into one word
// Ports: clk, rst_n (async active-low), start_sig (beat 0 marker), in_valid, in_bus[IN_WIDTH],
//        out_bus[OUT_WIDTH] (held until next completion), ready (1-cycle new-word pulse),
//        busy (word partially collected), frame_err (1-cycle partial-word-discarded pulse).
// Build option: define RXC_TIMEOUT_EN to drop a partial word after TIMEOUT_CYC idle cycles.
module mod_rx_commut
    import mod_commut_pkg::*;
#(
    parameter int unsigned IN_WIDTH      = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int unsigned NUMB_OF_BEATS = OUT_WIDTH / IN_WIDTH,
    parameter int unsigned TIMEOUT_CYC   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_sig,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_bus,
    output logic [OUT_WIDTH-1:0] out_bus,
    output logic                 ready,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int unsigned CW = cnt_w(NUMB_OF_BEATS);
    if (NUMB_OF_BEATS < 1 || OUT_WIDTH != IN_WIDTH * NUMB_OF_BEATS || TIMEOUT_CYC < 1)
        $error("mod_rx_commut: bad width/beat/timeout parameters");
    state_e               state_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] shft_q, shft_d, out_q;
    logic                 ready_q, err_q;
    logic                 collect, accept, restart, done, timeout;
    assign collect = state_q == COLLECT;
    assign accept  = in_valid && (start_sig || collect);
    assign restart = in_valid && start_sig && collect;
    // A start beat always begins a fresh word, even mid-collection.
    assign cnt_d   = (collect && !start_sig) ? cnt_q + 1'b1 : CW'(1);
    assign done    = cnt_d == CW'(NUMB_OF_BEATS);
    if (NUMB_OF_BEATS == 1) begin : g_one
        assign shft_d = in_bus;
    end else begin : g_many
        assign shft_d = {in_bus, shft_q[OUT_WIDTH-1:IN_WIDTH]};
    end
`ifdef RXC_TIMEOUT_EN
    mod_commut_gap_timer #(.CYC(TIMEOUT_CYC)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (!collect || in_valid),
        .dec_i    (collect && !in_valid),
        .expire_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shft_q  <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= accept && done;
            err_q   <= restart || timeout;
            if (accept) begin
                shft_q <= shft_d;
                if (done) begin
                    out_q   <= shft_d;
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= COLLECT;
                    cnt_q   <= cnt_d;
                end
            end else if (timeout) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end
        end
    end
    assign out_bus   = out_q;
    assign ready     = ready_q;
    assign busy      = collect;
    assign frame_err = err_q;
endmodule

// File: tb/tb_mod_rx_commut.sv
// tb_mod_rx_commut: directed self-checking bench for mod_rx_commut (8-bit beats, 32-bit words)
module tb_mod_rx_commut;
    logic        clk;
    logic        rst_n;
    logic        start_sig;
    logic        in_valid;
    logic [7:0]  in_bus;
    logic [31:0] out_bus;
    logic        ready;
    logic        busy;
    logic        frame_err;
    int          n_chk;
    int          n_err;
    int          rdy_cnt;
    int          cyc;
    int          t_first;

    mod_rx_commut #(.IN_WIDTH(8), .OUT_WIDTH(32), .NUMB_OF_BEATS(4), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_sig (start_sig),
        .in_valid  (in_valid),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the clock edge.
    task automatic send(input logic s, input logic v, input logic [7:0] d);
        start_sig = s;
        in_valid  = v;
        in_bus    = d;
        @(posedge clk);
        #1;
        cyc++;
        rdy_cnt += int'(ready);
    endtask

    task automatic word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(i == 0, 1'b1, w[8*i +: 8]);
    endtask

    initial begin
        n_chk = 0; n_err = 0; rdy_cnt = 0; cyc = 0;
        rst_n = 1'b0; start_sig = 1'b0; in_valid = 1'b0; in_bus = 8'h00;
        #3;
        chk("rst_out", out_bus, 32'h0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // non-start beat in IDLE is ignored
        send(1'b0, 1'b1, 8'h99);
        chk("idle_ign_busy", busy, 0);
        chk("idle_ign_err", frame_err, 0);
        // 1: consecutive beats
        send(1'b1, 1'b1, 8'h11);
        chk("t1_busy", busy, 1);
        send(1'b0, 1'b1, 8'h22);
        send(1'b0, 1'b1, 8'h33);
        chk("t1_noready", ready, 0);
        send(1'b0, 1'b1, 8'h44);
        chk("t1_ready", ready, 1);
        chk("t1_out", out_bus, 32'h44332211);
        chk("t1_busy_end", busy, 0);
        send(1'b0, 1'b0, 8'h00);
        chk("t1_pulse", ready, 0);
        chk("t1_hold", out_bus, 32'h44332211);
        // 2: gaps of 3 idle cycles
        rdy_cnt = 0;
        send(1'b1, 1'b1, 8'h11);
        for (int b = 1; b < 4; b++) begin
            for (int g = 0; g < 3; g++) begin
                send(1'b0, 1'b0, 8'hEE);
                chk("t2_busy", busy, 1);
            end
            send(1'b0, 1'b1, 8'(8'h11 * (b + 1)));
        end
        send(1'b0, 1'b0, 8'h00);
        chk("t2_rdycnt", rdy_cnt, 1);
        chk("t2_out", out_bus, 32'h44332211);
        // 3: restart mid-word
        send(1'b1, 1'b1, 8'hAA);
        send(1'b0, 1'b1, 8'hBB);
        chk("t3_noerr", frame_err, 0);
        send(1'b1, 1'b1, 8'h01);
        chk("t3_err", frame_err, 1);
        chk("t3_busy", busy, 1);
        send(1'b0, 1'b1, 8'h02);
        chk("t3_err_pulse", frame_err, 0);
        send(1'b0, 1'b1, 8'h03);
        send(1'b0, 1'b1, 8'h04);
        chk("t3_ready", ready, 1);
        chk("t3_out", out_bus, 32'h04030201);
        // 4: back-to-back, second start on the ready cycle
        word(32'h44332211);
        chk("t4_ready1", ready, 1);
        chk("t4_out1", out_bus, 32'h44332211);
        t_first = cyc;
        send(1'b1, 1'b1, 8'h55);
        chk("t4_noready", ready, 0);
        chk("t4_busy", busy, 1);
        send(1'b0, 1'b1, 8'h66);
        send(1'b0, 1'b1, 8'h77);
        send(1'b0, 1'b1, 8'h88);
        chk("t4_ready2", ready, 1);
        chk("t4_gap", cyc - t_first, 4);
        chk("t4_out2", out_bus, 32'h88776655);
        // 5: reset mid-word
        send(1'b1, 1'b1, 8'h11);
        send(1'b0, 1'b1, 8'h22);
        in_valid = 1'b0; start_sig = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_out", out_bus, 32'h0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", ready, 0);
        chk("t5_err", frame_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(1'b0, 1'b0, 8'h00);
        chk("t5_err_after", frame_err, 0);
        word(32'hD4C3B2A1);
        chk("t5_ready2", ready, 1);
        chk("t5_word", out_bus, 32'hD4C3B2A1);
        // 6: long idle gap
        send(1'b1, 1'b1, 8'h11);
        send(1'b0, 1'b1, 8'h22);
        for (int g = 0; g < 15; g++) send(1'b0, 1'b0, 8'h00);
        chk("t6_busy15", busy, 1);
        chk("t6_err15", frame_err, 0);
        send(1'b0, 1'b0, 8'h00);
`ifdef RXC_TIMEOUT_EN
        chk("t6_err", frame_err, 1);
        chk("t6_busy", busy, 0);
        word(32'h04030201);
        chk("t6_out", out_bus, 32'h04030201);
`else
        chk("t6_err", frame_err, 0);
        chk("t6_busy", busy, 1);
        send(1'b0, 1'b1, 8'h33);
        send(1'b0, 1'b1, 8'h44);
        chk("t6_ready", ready, 1);
        chk("t6_out", out_bus, 32'h44332211);
`endif
        send(1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
